// File: rtl/sync_pulse_scheduler.sv
// sync_pulse_scheduler
//   Fast-clock-side scheduler for ratio-based clock-domain crossings. It counts
//   fast cycles across each slow period (cfg_ratio+1 fast cycles) and emits the
//   synchronizer windows at fixed phases. Ratio updates and start/stop only take
//   effect on a period boundary, so a partial slow period is never produced.
//
// Ports
//   clk        in   fast clock, posedge
//   rst        in   asynchronous active-high reset
//   en         in   run request; dropping it stops at the next period boundary
//   cfg_ratio  in   requested ratio minus one
//   cfg_valid  in   ratio update request, held until cfg_ack
//   cfg_ack    out  one-cycle pulse, new ratio in effect from this cycle's period
//   slow_en    out  last fast cycle of each slow period
//   tx_sync    out  fast->slow launch window (same cycle as slow_en)
//   rx_sync    out  slow->fast capture window (first cycle of each period)
//   phase      out  current phase counter
//   running    out  high while in RUN
module sync_pulse_scheduler #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [CNT_W-1:0] cfg_ratio,
    input  logic             cfg_valid,
    output logic             cfg_ack,
    output logic             slow_en,
    output logic             tx_sync,
    output logic             rx_sync,
    output logic [CNT_W-1:0] phase,
    output logic             running
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t           state_r;
    state_t           state_nxt_s;
    logic [CNT_W-1:0] phase_r;
    logic [CNT_W-1:0] phase_nxt_s;
    logic [CNT_W-1:0] ratio_r;
    logic [CNT_W-1:0] ratio_nxt_s;
    logic             block_r;
    logic             block_nxt_s;
    logic             load_s;
    logic             boundary_s;
    logic             slow_en_r;
    logic             rx_sync_r;
    logic             cfg_ack_r;
    logic             running_r;
    logic             slow_en_nxt_s;
    logic             rx_sync_nxt_s;
    logic             running_nxt_s;

    // Next state, next phase, ratio load decision and the next-cycle pulse values.
    // Pulses are computed from the next phase/ratio so the registered outputs line
    // up with the phase value they accompany.
    always_comb begin
        state_nxt_s   = state_r;
        phase_nxt_s   = phase_r;
        ratio_nxt_s   = ratio_r;
        load_s        = 1'b0;
        boundary_s    = 1'b0;
        block_nxt_s   = block_r;
        slow_en_nxt_s = 1'b0;
        rx_sync_nxt_s = 1'b0;
        running_nxt_s = 1'b0;

        case (state_r)
            ST_IDLE: begin
                load_s      = cfg_valid & ~block_r;
                phase_nxt_s = {CNT_W{1'b0}};
                if (en) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                boundary_s = (phase_r == ratio_r);
                if (boundary_s) begin
                    load_s      = cfg_valid & ~block_r;
                    phase_nxt_s = {CNT_W{1'b0}};
                    if (en) begin
                        state_nxt_s = ST_RUN;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end else begin
                    phase_nxt_s = phase_r + {{(CNT_W-1){1'b0}}, 1'b1};
                    state_nxt_s = ST_RUN;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                phase_nxt_s = {CNT_W{1'b0}};
            end
        endcase

        if (load_s) begin
            ratio_nxt_s = cfg_ratio;
        end else begin
            ratio_nxt_s = ratio_r;
        end

        // A loaded request stays blocked until cfg_valid is seen low, so one
        // request held high past its ack is never accepted twice.
        if (load_s) begin
            block_nxt_s = 1'b1;
        end else if (!cfg_valid) begin
            block_nxt_s = 1'b0;
        end else begin
            block_nxt_s = block_r;
        end

        if (state_nxt_s == ST_RUN) begin
            running_nxt_s = 1'b1;
            rx_sync_nxt_s = (phase_nxt_s == {CNT_W{1'b0}});
            slow_en_nxt_s = (phase_nxt_s == ratio_nxt_s);
        end else begin
            running_nxt_s = 1'b0;
            rx_sync_nxt_s = 1'b0;
            slow_en_nxt_s = 1'b0;
        end
    end

    // State, counter, ratio and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            phase_r   <= {CNT_W{1'b0}};
            ratio_r   <= {CNT_W{1'b0}};
            block_r   <= 1'b0;
            slow_en_r <= 1'b0;
            rx_sync_r <= 1'b0;
            cfg_ack_r <= 1'b0;
            running_r <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            phase_r   <= phase_nxt_s;
            ratio_r   <= ratio_nxt_s;
            block_r   <= block_nxt_s;
            slow_en_r <= slow_en_nxt_s;
            rx_sync_r <= rx_sync_nxt_s;
            cfg_ack_r <= load_s;
            running_r <= running_nxt_s;
        end
    end

    assign phase   = phase_r;
    assign slow_en = slow_en_r;
    assign tx_sync = slow_en_r;
    assign rx_sync = rx_sync_r;
    assign cfg_ack = cfg_ack_r;
    assign running = running_r;

endmodule

// File: tb/tb_sync_pulse_scheduler.sv
module tb_sync_pulse_scheduler;

    logic       clk;
    logic       rst;
    logic       en;
    logic [3:0] cfg_ratio;
    logic       cfg_valid;
    logic       cfg_ack;
    logic       slow_en;
    logic       tx_sync;
    logic       rx_sync;
    logic [3:0] phase;
    logic       running;

    int total;
    int bad;

    logic [8:0] obs;
    assign obs = {running, phase, slow_en, tx_sync, rx_sync, cfg_ack};

    sync_pulse_scheduler #(.CNT_W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .cfg_ratio (cfg_ratio),
        .cfg_valid (cfg_valid),
        .cfg_ack   (cfg_ack),
        .slow_en   (slow_en),
        .tx_sync   (tx_sync),
        .rx_sync   (rx_sync),
        .phase     (phase),
        .running   (running)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // expected {running, phase, slow_en, tx_sync, rx_sync, cfg_ack}
    function automatic logic [8:0] ex(input logic r, input logic [3:0] ph,
                                      input logic s, input logic x, input logic a);
        return {r, ph, s, s, x, a};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; en = 1'b0; cfg_valid = 1'b0; cfg_ratio = 4'd0;
        #12;
        rst = 1'b0;
        step();
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if (obs !== ex(1'b0, 4'd0, 1'b0, 1'b0, 1'b0)) begin
            bad++; $display("FAIL reset_state got=%b exp=%b", obs, ex(1'b0, 4'd0, 1'b0, 1'b0, 1'b0));
        end
    endtask

    task automatic test_cfg_idle_run();
        logic [8:0] exp_v [5];
        cfg_ratio = 4'd3; cfg_valid = 1'b1;
        step();
        total++;
        if (obs !== ex(1'b0, 4'd0, 1'b0, 1'b0, 1'b1)) begin
            bad++; $display("FAIL idle_ack got=%b exp=%b", obs, ex(1'b0, 4'd0, 1'b0, 1'b0, 1'b1));
        end
        cfg_valid = 1'b0; en = 1'b1;
        exp_v[0] = ex(1'b1, 4'd0, 1'b0, 1'b1, 1'b0);
        exp_v[1] = ex(1'b1, 4'd1, 1'b0, 1'b0, 1'b0);
        exp_v[2] = ex(1'b1, 4'd2, 1'b0, 1'b0, 1'b0);
        exp_v[3] = ex(1'b1, 4'd3, 1'b1, 1'b0, 1'b0);
        exp_v[4] = ex(1'b1, 4'd0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step();
            total++;
            if (obs !== exp_v[i]) begin
                bad++; $display("FAIL run_ratio3[%0d] got=%b exp=%b", i, obs, exp_v[i]);
            end
        end
    endtask

    task automatic test_ratio_zero();
        do_reset();
        en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            total++;
            if (obs !== ex(1'b1, 4'd0, 1'b1, 1'b1, 1'b0)) begin
                bad++; $display("FAIL ratio0[%0d] got=%b exp=%b", i, obs, ex(1'b1, 4'd0, 1'b1, 1'b1, 1'b0));
            end
        end
    endtask

    task automatic test_cfg_in_run();
        logic [8:0] exp_v [7];
        do_reset();
        // simultaneous en and cfg in IDLE: first period already uses ratio 3
        cfg_ratio = 4'd3; cfg_valid = 1'b1; en = 1'b1;
        exp_v[0] = ex(1'b1, 4'd0, 1'b0, 1'b1, 1'b1);
        exp_v[1] = ex(1'b1, 4'd1, 1'b0, 1'b0, 1'b0);
        exp_v[2] = ex(1'b1, 4'd2, 1'b0, 1'b0, 1'b0);
        exp_v[3] = ex(1'b1, 4'd3, 1'b1, 1'b0, 1'b0);
        exp_v[4] = ex(1'b1, 4'd0, 1'b0, 1'b1, 1'b1);
        exp_v[5] = ex(1'b1, 4'd1, 1'b1, 1'b0, 1'b0);
        exp_v[6] = ex(1'b1, 4'd0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 7; i++) begin
            step();
            if (i == 0) cfg_valid = 1'b0;
            if (i == 1) begin cfg_ratio = 4'd1; cfg_valid = 1'b1; end
            if (i == 4) cfg_valid = 1'b0;
            total++;
            if (obs !== exp_v[i]) begin
                bad++; $display("FAIL cfg_in_run[%0d] got=%b exp=%b", i, obs, exp_v[i]);
            end
        end
        step();
        total++;
        if (obs !== ex(1'b1, 4'd1, 1'b1, 1'b0, 1'b0)) begin
            bad++; $display("FAIL ratio1_period got=%b exp=%b", obs, ex(1'b1, 4'd1, 1'b1, 1'b0, 1'b0));
        end
    endtask

    task automatic test_stop();
        logic [8:0] exp_v [5];
        do_reset();
        cfg_ratio = 4'd3; cfg_valid = 1'b1; en = 1'b1;
        exp_v[0] = ex(1'b1, 4'd0, 1'b0, 1'b1, 1'b1);
        exp_v[1] = ex(1'b1, 4'd1, 1'b0, 1'b0, 1'b0);
        exp_v[2] = ex(1'b1, 4'd2, 1'b0, 1'b0, 1'b0);
        exp_v[3] = ex(1'b1, 4'd3, 1'b1, 1'b0, 1'b0);
        exp_v[4] = ex(1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step();
            if (i == 0) cfg_valid = 1'b0;
            if (i == 1) en = 1'b0;
            total++;
            if (obs !== exp_v[i]) begin
                bad++; $display("FAIL stop[%0d] got=%b exp=%b", i, obs, exp_v[i]);
            end
        end
    endtask

    task automatic test_stop_with_cfg();
        do_reset();
        cfg_ratio = 4'd3; cfg_valid = 1'b1; en = 1'b1;
        step(); cfg_valid = 1'b0;
        step(); step(); step();
        // boundary cycle: stop and request ratio 1 together
        en = 1'b0; cfg_ratio = 4'd1; cfg_valid = 1'b1;
        step();
        total++;
        if (obs !== ex(1'b0, 4'd0, 1'b0, 1'b0, 1'b1)) begin
            bad++; $display("FAIL stop_cfg_ack got=%b exp=%b", obs, ex(1'b0, 4'd0, 1'b0, 1'b0, 1'b1));
        end
        cfg_valid = 1'b0; en = 1'b1;
        step(); step();
        total++;
        if (obs !== ex(1'b1, 4'd1, 1'b1, 1'b0, 1'b0)) begin
            bad++; $display("FAIL stop_cfg_ratio got=%b exp=%b", obs, ex(1'b1, 4'd1, 1'b1, 1'b0, 1'b0));
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        cfg_ratio = 4'd3; cfg_valid = 1'b1; en = 1'b1;
        step(); cfg_valid = 1'b0;
        step(); step();
        total++;
        if (phase !== 4'd2) begin
            bad++; $display("FAIL pre_rst_phase got=%0d exp=2", phase);
        end
        #2 rst = 1'b1;
        #1;
        total++;
        if (obs !== ex(1'b0, 4'd0, 1'b0, 1'b0, 1'b0)) begin
            bad++; $display("FAIL async_rst got=%b exp=%b", obs, ex(1'b0, 4'd0, 1'b0, 1'b0, 1'b0));
        end
        #1 rst = 1'b0;
        step();
        total++;
        if (obs !== ex(1'b1, 4'd0, 1'b1, 1'b1, 1'b0)) begin
            bad++; $display("FAIL post_rst_ratio0 got=%b exp=%b", obs, ex(1'b1, 4'd0, 1'b1, 1'b1, 1'b0));
        end
    endtask

    task automatic test_back_to_back();
        int acks;
        do_reset();
        cfg_ratio = 4'd2; cfg_valid = 1'b1;
        step();
        total++;
        if (cfg_ack !== 1'b1) begin
            bad++; $display("FAIL first_ack got=%b exp=1", cfg_ack);
        end
        acks = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (cfg_ack === 1'b1) acks++;
        end
        total++;
        if (acks !== 0) begin
            bad++; $display("FAIL held_no_reack got=%0d exp=0", acks);
        end
        cfg_valid = 1'b0;
        step();
        cfg_valid = 1'b1;
        step();
        total++;
        if (cfg_ack !== 1'b1) begin
            bad++; $display("FAIL second_ack got=%b exp=1", cfg_ack);
        end
        cfg_valid = 1'b0;
        step();
        total++;
        if (cfg_ack !== 1'b0) begin
            bad++; $display("FAIL ack_one_cycle got=%b exp=0", cfg_ack);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst = 1'b1; en = 1'b0; cfg_valid = 1'b0; cfg_ratio = 4'd0;
        test_reset();
        test_cfg_idle_run();
        test_ratio_zero();
        test_cfg_in_run();
        test_stop();
        test_stop_with_cfg();
        test_async_reset();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
